// File: rtl/bsg_link_ddr_downstream_init_seq.sv
// Bring-up sequencer for the downstream side of a DDR link: holds the link core in reset,
// waits for link enable, releases the consumer reset and retries failed attempts.
module bsg_link_ddr_downstream_init_seq #(
    parameter int reset_hold_cycles_p = 16,
    parameter int timeout_cycles_p    = 1024,
    parameter int chip_reset_cycles_p = 16,
    parameter int max_retries_p       = 3,
    localparam int retries_width_lp   = (max_retries_p > 0) ? $clog2(max_retries_p + 1) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        link_enable_i,
    output logic                        link_reset_o,
    output logic                        chip_reset_o,
    output logic                        ready_o,
    output logic                        error_o,
    output logic [retries_width_lp-1:0] retries_o
);

    localparam int max_hold_lp    = (reset_hold_cycles_p > chip_reset_cycles_p) ?
                                    reset_hold_cycles_p : chip_reset_cycles_p;
    localparam int max_cycles_lp  = (max_hold_lp > timeout_cycles_p) ? max_hold_lp : timeout_cycles_p;
    localparam int cnt_width_lp   = $clog2(max_cycles_lp + 1);

    localparam logic [cnt_width_lp-1:0] reset_hold_last_lp = cnt_width_lp'(reset_hold_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] timeout_last_lp    = cnt_width_lp'(timeout_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] chip_reset_last_lp = cnt_width_lp'(chip_reset_cycles_p - 1);
    localparam logic [retries_width_lp-1:0] max_retries_lp = retries_width_lp'(max_retries_p);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LINK_RST = 3'd1,
        WAIT_EN  = 3'd2,
        CHIP_RST = 3'd3,
        ACTIVE   = 3'd4,
        FAIL     = 3'd5
    } state_e;

    state_e                      state_r;
    state_e                      next_state_s;
    state_e                      fail_state_s;
    logic [cnt_width_lp-1:0]     cnt_r;
    logic [cnt_width_lp-1:0]     next_cnt_s;
    logic [retries_width_lp-1:0] retries_r;
    logic [retries_width_lp-1:0] next_retries_s;
    logic [retries_width_lp-1:0] fail_retries_s;
    logic                        next_link_reset_s;
    logic                        next_chip_reset_s;
    logic                        next_ready_s;
    logic                        next_error_s;

    // Outcome of a failed attempt: retry with a saturating count, or give up
    always_comb begin
        fail_state_s   = FAIL;
        fail_retries_s = retries_r;
        if (retries_r == max_retries_lp) begin
            fail_state_s   = FAIL;
            fail_retries_s = retries_r;
        end else begin
            fail_state_s   = LINK_RST;
            fail_retries_s = retries_r + 1'b1;
        end
    end

    // Next-state and retry bookkeeping; stop_i overrides everything
    always_comb begin
        next_state_s   = state_r;
        next_retries_s = retries_r;
        if (stop_i) begin
            next_state_s   = IDLE;
            next_retries_s = '0;
        end else begin
            case (state_r)
                IDLE, FAIL: begin
                    if (start_i) begin
                        next_state_s   = LINK_RST;
                        next_retries_s = '0;
                    end else begin
                        next_state_s   = state_r;
                    end
                end
                LINK_RST: begin
                    if (cnt_r == reset_hold_last_lp) begin
                        next_state_s = WAIT_EN;
                    end else begin
                        next_state_s = LINK_RST;
                    end
                end
                WAIT_EN: begin
                    // link enable wins over a timeout landing on the same cycle
                    if (link_enable_i) begin
                        next_state_s = CHIP_RST;
                    end else if (cnt_r == timeout_last_lp) begin
                        next_state_s   = fail_state_s;
                        next_retries_s = fail_retries_s;
                    end else begin
                        next_state_s = WAIT_EN;
                    end
                end
                CHIP_RST: begin
                    if (!link_enable_i) begin
                        next_state_s   = fail_state_s;
                        next_retries_s = fail_retries_s;
                    end else if (cnt_r == chip_reset_last_lp) begin
                        next_state_s   = ACTIVE;
                        next_retries_s = '0;
                    end else begin
                        next_state_s = CHIP_RST;
                    end
                end
                ACTIVE: begin
                    if (!link_enable_i) begin
                        next_state_s   = fail_state_s;
                        next_retries_s = fail_retries_s;
                    end else begin
                        next_state_s = ACTIVE;
                    end
                end
                default: begin
                    next_state_s   = IDLE;
                    next_retries_s = '0;
                end
            endcase
        end
    end

    // Shared cycle counter: restarts on every state change, only runs in timed states
    always_comb begin
        next_cnt_s = '0;
        if (next_state_s != state_r) begin
            next_cnt_s = '0;
        end else if ((state_r == LINK_RST) || (state_r == WAIT_EN) || (state_r == CHIP_RST)) begin
            next_cnt_s = cnt_r + 1'b1;
        end else begin
            next_cnt_s = '0;
        end
    end

    // Moore decode of the state being entered, so outputs register alongside the state
    always_comb begin
        next_link_reset_s = 1'b1;
        next_chip_reset_s = 1'b1;
        next_ready_s      = 1'b0;
        next_error_s      = 1'b0;
        case (next_state_s)
            IDLE, LINK_RST: begin
                next_link_reset_s = 1'b1;
                next_chip_reset_s = 1'b1;
            end
            WAIT_EN, CHIP_RST: begin
                next_link_reset_s = 1'b0;
                next_chip_reset_s = 1'b1;
            end
            ACTIVE: begin
                next_link_reset_s = 1'b0;
                next_chip_reset_s = 1'b0;
                next_ready_s      = 1'b1;
            end
            FAIL: begin
                next_link_reset_s = 1'b1;
                next_chip_reset_s = 1'b1;
                next_error_s      = 1'b1;
            end
            default: begin
                next_link_reset_s = 1'b1;
                next_chip_reset_s = 1'b1;
            end
        endcase
    end

    // State, counter, retry count and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            retries_r    <= '0;
            link_reset_o <= 1'b1;
            chip_reset_o <= 1'b1;
            ready_o      <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= next_cnt_s;
            retries_r    <= next_retries_s;
            link_reset_o <= next_link_reset_s;
            chip_reset_o <= next_chip_reset_s;
            ready_o      <= next_ready_s;
            error_o      <= next_error_s;
        end
    end

    assign retries_o = retries_r;

endmodule

// File: tb/tb_bsg_link_ddr_downstream_init_seq.sv
// Scoreboard bench for the downstream link bring-up sequencer (reset_hold=4, timeout=8,
// chip_reset=3, max_retries=2).
module tb_bsg_link_ddr_downstream_init_seq;

    localparam int RH = 4;
    localparam int TO = 8;
    localparam int CR = 3;
    localparam int MR = 2;

    localparam int M_IDLE = 0;
    localparam int M_LRST = 1;
    localparam int M_WAIT = 2;
    localparam int M_CRST = 3;
    localparam int M_ACT  = 4;
    localparam int M_FAIL = 5;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       stop_i;
    logic       link_enable_i;
    logic       link_reset_o;
    logic       chip_reset_o;
    logic       ready_o;
    logic       error_o;
    logic [1:0] retries_o;

    int n_checks = 0;
    int n_fail   = 0;

    int m_state;
    int m_left;
    int m_retry;
    logic [5:0] exp_q[$];

    bsg_link_ddr_downstream_init_seq #(
        .reset_hold_cycles_p(RH),
        .timeout_cycles_p   (TO),
        .chip_reset_cycles_p(CR),
        .max_retries_p      (MR)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .link_enable_i(link_enable_i),
        .link_reset_o (link_reset_o),
        .chip_reset_o (chip_reset_o),
        .ready_o      (ready_o),
        .error_o      (error_o),
        .retries_o    (retries_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_left  = 0;
        m_retry = 0;
    endtask

    task automatic model_fail();
        if (m_retry == MR) begin
            m_state = M_FAIL;
        end else begin
            m_retry = m_retry + 1;
            m_state = M_LRST;
            m_left  = RH;
        end
    endtask

    // m_left counts the cycles still to be spent in a timed state
    task automatic model_step(input logic s, input logic p, input logic e);
        if (p) begin
            m_state = M_IDLE;
            m_retry = 0;
        end else begin
            case (m_state)
                M_IDLE, M_FAIL: if (s) begin m_state = M_LRST; m_left = RH; m_retry = 0; end
                M_LRST: if (m_left == 1) begin m_state = M_WAIT; m_left = TO; end else m_left--;
                M_WAIT: if (e) begin m_state = M_CRST; m_left = CR; end
                        else if (m_left == 1) model_fail();
                        else m_left--;
                M_CRST: if (!e) model_fail();
                        else if (m_left == 1) begin m_state = M_ACT; m_retry = 0; end
                        else m_left--;
                M_ACT:  if (!e) model_fail();
                default: ;
            endcase
        end
    endtask

    function automatic logic [5:0] model_outputs();
        logic lr, cr, rd, er;
        lr = (m_state == M_IDLE) || (m_state == M_LRST) || (m_state == M_FAIL);
        cr = (m_state != M_ACT);
        rd = (m_state == M_ACT);
        er = (m_state == M_FAIL);
        return {lr, cr, rd, er, 2'(m_retry)};
    endfunction

    task automatic step(input logic s, input logic p, input logic e);
        logic [5:0] exp_v;
        start_i       = s;
        stop_i        = p;
        link_enable_i = e;
        model_step(s, p, e);
        exp_q.push_back(model_outputs());
        @(posedge clk_i);
        #1;
        exp_v = exp_q.pop_front();
        check_value("outputs", {26'd0, link_reset_o, chip_reset_o, ready_o, error_o, retries_o},
                    {26'd0, exp_v});
    endtask

    initial begin
        int n;
        reset_i       = 1'b1;
        start_i       = 1'b0;
        stop_i        = 1'b0;
        link_enable_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_value("reset_state", {link_reset_o, chip_reset_o, ready_o, error_o, retries_o}, 6'b110000);
        reset_i = 1'b0;

        // clean bring-up, enable rises on the 2nd WAIT_EN cycle
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_value("clean_lrst_held", link_reset_o, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_value("clean_lrst_released", link_reset_o, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        check_value("clean_chip_rst_held", chip_reset_o, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_value("clean_chip_rst_released", chip_reset_o, 1'b0);
        check_value("clean_ready", ready_o, 1'b1);
        check_value("clean_retries", retries_o, 2'd0);

        // link drop in ACTIVE, then recovery
        step(1'b0, 1'b0, 1'b0);
        check_value("drop_ready", ready_o, 1'b0);
        check_value("drop_link_reset", link_reset_o, 1'b1);
        check_value("drop_retries", retries_o, 2'd1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check_value("recover_ready", ready_o, 1'b1);
        check_value("recover_retries", retries_o, 2'd0);

        // start and stop together in IDLE
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_value("start_stop_idle", link_reset_o, 1'b1);

        // stop in WAIT_EN
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_value("stop_wait_en", link_reset_o, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check_value("stop_stays_idle", link_reset_o, 1'b1);

        // enable on the 8th WAIT_EN cycle beats the timeout
        step(1'b1, 1'b0, 1'b0);
        repeat (11) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_value("late_en_link_reset", link_reset_o, 1'b0);
        check_value("late_en_retries", retries_o, 2'd0);
        step(1'b0, 1'b1, 1'b0);

        // retry exhaustion with enable held low: 3 attempts of 12 cycles
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (!error_o && n < 60) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            if (n == 11) check_value("exhaust_retries_0", retries_o, 2'd0);
            if (n == 12) check_value("exhaust_retries_1", retries_o, 2'd1);
            if (n == 24) check_value("exhaust_retries_2", retries_o, 2'd2);
        end
        check_value("exhaust_cycles", n, 36);
        check_value("fail_outputs", {link_reset_o, chip_reset_o, ready_o, error_o}, 4'b1101);
        step(1'b0, 1'b0, 1'b1);
        check_value("fail_sticky", error_o, 1'b1);

        // restart from FAIL
        step(1'b1, 1'b0, 1'b0);
        check_value("restart_error", error_o, 1'b0);
        check_value("restart_retries", retries_o, 2'd0);
        check_value("restart_link_reset", link_reset_o, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check_value("restart_wait_en", link_reset_o, 1'b0);

        // asynchronous reset while ACTIVE
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check_value("pre_reset_ready", ready_o, 1'b1);
        #3;
        reset_i = 1'b1;
        #1;
        check_value("async_reset", {link_reset_o, chip_reset_o, ready_o, error_o, retries_o}, 6'b110000);
        model_reset();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b1);
        check_value("post_reset_idle", ready_o, 1'b0);
        check_value("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
